// File: rtl/serial_addsub_pkg.sv
// ============================================================================
//  Module   : serial_addsub_pkg
//  Brief    : Shared FSM state type and reset state for serial_addsub.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam state_t C_RESET_STATE = IDLE;

endpackage

`default_nettype wire

// File: rtl/serial_addsub_fa_cell.sv
// ============================================================================
//  Module   : fa_cell
//  Brief    : 1-bit full adder used as the serial adder's only arithmetic cell.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
//  Module   : serial_addsub
//  Brief    : Bit-serial LSB-first adder/subtractor with valid/ready handshake,
//             one result bit per clock, carry/overflow/zero flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    input  logic         sub,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_opa;
    logic [N-1:0]   r_opb;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;
    logic [N-2:0]   r_sr;
    logic [N-1:0]   r_z;
    logic           r_cout;
    logic           r_ovf;
    logic           r_zero;

    logic           w_s;
    logic           w_c;
    logic           w_last;
    logic [N-1:0]   w_res;

    fa_cell u_fa (
        .a  (r_opa[0]),
        .b  (r_opb[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_c)
    );

    assign w_last = (r_cnt == CW'(N - 1));
    // Only N-1 bits are kept between cycles; the final bit joins on the last cycle.
    assign w_res  = {w_s, r_sr};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_RESET_STATE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_z     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opa   <= x;
                        r_opb   <= sub ? ~y : y;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        r_sr    <= '0;
                    end
                end
                RUN: begin
                    r_sr    <= w_res[N-1:1];
                    r_opa   <= r_opa >> 1;
                    r_opb   <= r_opb >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    // Result registers update only here, so they hold through DONE and IDLE.
                    if (w_last) begin
                        r_z    <= w_res;
                        r_cout <= w_c;
                        r_ovf  <= r_carry ^ w_c;
                        r_zero <= ~|w_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign z         = r_z;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

`default_nettype wire
